// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcode values and fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned CPU_PC_W    = 4;
    localparam int unsigned CPU_INSTR_W = 8;
    localparam int unsigned CPU_CNT_W   = 8;

    // Opcodes carried in the upper nibble of an instruction
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_VALID  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment, wraps modulo 2^PC_W.
module program_counter
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = CPU_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next PC: jump target beats increment; increment wraps silently
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/VALID/HALTED FSM, instruction register and
// saturating fetch counter. Define FETCH_PROTO_CHECK_EN to enable the sticky
// proto_err detector for PC requests arriving during FETCH.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = CPU_PC_W,
    parameter int unsigned INSTR_W = CPU_INSTR_W,
    parameter int unsigned CNT_W   = CPU_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_enable,
    input  logic               pc_load,
    input  logic               halt,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    imem_addr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic               proto_err
);

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
    logic               instr_valid_q, instr_valid_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic               pc_load_c, pc_inc_c;

    program_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load_c),
        .inc       (pc_inc_c),
        .load_addr (jump_addr),
        .pc        (pc)
    );

    // Next-state and datapath control; halt wins over every PC request
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        pc_load_c     = 1'b0;
        pc_inc_c      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (halt) begin
                    state_d       = ST_HALTED;
                    instr_valid_d = 1'b0;
                end else begin
                    instruction_d = imem_data;
                    instr_valid_d = 1'b1;
                    if (fetch_count_q != {CNT_W{1'b1}}) begin
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                    end
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (halt) begin
                    state_d       = ST_HALTED;
                    instr_valid_d = 1'b0;
                end else if (pc_load) begin
                    pc_load_c     = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (pc_enable) begin
                    pc_inc_c      = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            ST_HALTED: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = ST_FETCH;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // FSM and instruction-side registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef FETCH_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;

    // Sticky flag: PC request seen while a fetch is still in flight
    always_comb begin
        proto_err_d = proto_err_q;
        if ((state_q == ST_FETCH) && (pc_enable || pc_load)) begin
            proto_err_d = 1'b1;
        end
    end

    // Protocol-error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

    assign imem_addr   = pc;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
`ifdef FETCH_PROTO_CHECK_EN
    localparam logic PEXP = 1'b1;
`else
    localparam logic PEXP = 1'b0;
`endif

    typedef struct {
        logic       en;
        logic       ld;
        logic       hl;
        logic [3:0] ja;
        logic [3:0] e_pc;
        logic [7:0] e_instr;
        logic       e_valid;
        logic [7:0] e_cnt;
        logic       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pc_enable = 1'b0;
    logic       pc_load = 1'b0;
    logic       halt = 1'b0;
    logic [3:0] jump_addr = 4'h0;
    logic [7:0] imem_data;
    logic [3:0] imem_addr;
    logic [3:0] pc;
    logic [7:0] instruction;
    logic       instr_valid;
    logic [7:0] fetch_count;
    logic       proto_err;

    logic [7:0] imem [16];
    int         errors = 0;
    int         checks = 0;
    vec_t       vecs [25];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_enable   (pc_enable),
        .pc_load     (pc_load),
        .halt        (halt),
        .jump_addr   (jump_addr),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    function automatic vec_t mk(input logic en, input logic ld, input logic hl,
                                input logic [3:0] ja, input logic [3:0] p,
                                input logic [7:0] ins, input logic v,
                                input logic [7:0] c, input logic e);
        vec_t r;
        r.en = en; r.ld = ld; r.hl = hl; r.ja = ja;
        r.e_pc = p; r.e_instr = ins; r.e_valid = v; r.e_cnt = c; r.e_err = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic ld, input logic hl, input logic [3:0] ja);
        pc_enable = en;
        pc_load   = ld;
        halt      = hl;
        jump_addr = ja;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] p, input logic [7:0] ins,
                           input logic v, input logic [7:0] c, input logic e);
        chk({tag, " pc"}, 32'(pc), 32'(p));
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'(p));
        chk({tag, " instr"}, 32'(instruction), 32'(ins));
        chk({tag, " valid"}, 32'(instr_valid), 32'(v));
        chk({tag, " count"}, 32'(fetch_count), 32'(c));
        chk({tag, " err"}, 32'(proto_err), 32'(e));
    endtask

    initial begin
        imem[0] = 8'h05;
        for (int i = 1; i < 16; i++) imem[i] = 8'(i * 17);

        //            en ld hl ja     pc     instr  v  cnt    err
        vecs[0]  = mk(N, N, N, 4'h0, 4'h0, 8'h05, Y, 8'd1,  N);
        vecs[1]  = mk(N, N, N, 4'h0, 4'h0, 8'h05, Y, 8'd1,  N);
        vecs[2]  = mk(Y, N, N, 4'h0, 4'h1, 8'h05, N, 8'd1,  N);
        vecs[3]  = mk(N, N, N, 4'h0, 4'h1, 8'h11, Y, 8'd2,  N);
        vecs[4]  = mk(Y, N, N, 4'h0, 4'h2, 8'h11, N, 8'd2,  N);
        vecs[5]  = mk(N, N, N, 4'h0, 4'h2, 8'h22, Y, 8'd3,  N);
        vecs[6]  = mk(Y, Y, N, 4'hA, 4'hA, 8'h22, N, 8'd3,  N);
        vecs[7]  = mk(N, N, N, 4'h0, 4'hA, 8'hAA, Y, 8'd4,  N);
        vecs[8]  = mk(N, Y, N, 4'h3, 4'h3, 8'hAA, N, 8'd4,  N);
        vecs[9]  = mk(N, N, N, 4'h0, 4'h3, 8'h33, Y, 8'd5,  N);
        vecs[10] = mk(Y, N, N, 4'h0, 4'h4, 8'h33, N, 8'd5,  N);
        vecs[11] = mk(N, N, N, 4'h0, 4'h4, 8'h44, Y, 8'd6,  N);
        vecs[12] = mk(N, Y, N, 4'hF, 4'hF, 8'h44, N, 8'd6,  N);
        vecs[13] = mk(N, N, N, 4'h0, 4'hF, 8'hFF, Y, 8'd7,  N);
        vecs[14] = mk(Y, N, N, 4'h0, 4'h0, 8'hFF, N, 8'd7,  N);
        vecs[15] = mk(N, N, N, 4'h0, 4'h0, 8'h05, Y, 8'd8,  N);
        vecs[16] = mk(Y, N, N, 4'h0, 4'h1, 8'h05, N, 8'd8,  N);
        vecs[17] = mk(Y, N, N, 4'h0, 4'h1, 8'h11, Y, 8'd9,  PEXP);
        vecs[18] = mk(N, N, N, 4'h0, 4'h1, 8'h11, Y, 8'd9,  PEXP);
        vecs[19] = mk(N, Y, N, 4'h6, 4'h6, 8'h11, N, 8'd9,  PEXP);
        vecs[20] = mk(N, N, N, 4'h0, 4'h6, 8'h66, Y, 8'd10, PEXP);
        vecs[21] = mk(N, Y, Y, 4'h2, 4'h6, 8'h66, N, 8'd10, PEXP);
        vecs[22] = mk(Y, N, N, 4'h0, 4'h6, 8'h66, N, 8'd10, PEXP);
        vecs[23] = mk(N, Y, N, 4'h1, 4'h6, 8'h66, N, 8'd10, PEXP);
        vecs[24] = mk(N, N, N, 4'h0, 4'h6, 8'h66, N, 8'd10, PEXP);

        // Reset state
        step();
        step();
        chk_all("reset", 4'h0, 8'h00, N, 8'd0, N);
        rst = 1'b0;

        // Main vector table, one clock edge per row
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].en, vecs[i].ld, vecs[i].hl, vecs[i].ja);
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_valid, vecs[i].e_cnt, vecs[i].e_err);
        end

        // Reset out of HALTED
        drive(N, N, N, 4'h0);
        rst = 1'b1;
        #1;
        chk_all("halt_rst", 4'h0, 8'h00, N, 8'd0, N);
        step();
        rst = 1'b0;

        // Fetch counter saturation: 260 fetches, alternating fetch and advance
        for (int i = 0; i < 260; i++) begin
            drive(N, N, N, 4'h0);
            step();
            if (i >= 252) begin
                chk($sformatf("sat%0d count", i), 32'(fetch_count),
                    (i >= 254) ? 32'd255 : 32'(i + 1));
                chk($sformatf("sat%0d valid", i), 32'(instr_valid), 32'd1);
            end
            drive(Y, N, N, 4'h0);
            step();
        end
        drive(N, N, N, 4'h0);
        chk("sat_end pc", 32'(pc), 32'h4);
        chk("sat_end valid", 32'(instr_valid), 32'd0);

        // Asynchronous reset in the middle of FETCH, well before the next edge
        #2;
        rst = 1'b1;
        #1;
        chk_all("midfetch_rst", 4'h0, 8'h00, N, 8'd0, N);
        step();
        rst = 1'b0;

        // Halt during FETCH: nothing is latched, state stays frozen
        drive(N, N, Y, 4'h0);
        step();
        chk_all("halt_fetch", 4'h0, 8'h00, N, 8'd0, N);
        drive(Y, N, N, 4'h0);
        step();
        drive(N, N, N, 4'h0);
        step();
        chk("halt_fetch_hold pc", 32'(pc), 32'h0);
        chk("halt_fetch_hold valid", 32'(instr_valid), 32'd0);
        chk("halt_fetch_hold count", 32'(fetch_count), 32'd0);

        // Reset then first fetch from address 0 again
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk_all("refetch", 4'h0, 8'h05, Y, 8'd1, N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter PC_W, default 4, program-counter and instruction-memory address width.
REQ-002 SHALL provide parameter INSTR_W, default 8, instruction width: opcode in the upper 4 bits, operand in the lower 4 bits.
REQ-003 SHALL provide parameter CNT_W, default 8, fetch-counter width.
REQ-004 SHALL provide ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- pc_enable  in  1  advance PC by one (from control unit).
- pc_load  in  1  load PC from jump_addr (from control unit).
- halt  in  1  stop fetching (from control unit).
- jump_addr  in  PC_W  jump target; the operand field of the current instruction.
- imem_data  in  INSTR_W  combinational read data from instruction memory.
- imem_addr  out  PC_W  instruction-memory address; always equals pc.
- pc  out  PC_W  current program counter.
- instruction  out  INSTR_W  registered instruction presented to the control unit.
- instr_valid  out  1  instruction is stable and decodable.
- fetch_count  out  CNT_W  number of instructions latched.
- proto_err  out  1  sticky protocol-error flag.

Function
REQ-005 SHALL implement the FSM states FETCH, VALID and HALTED.
REQ-006 SHALL, in FETCH, latch imem_data into instruction at the clock edge, set instr_valid=1, increment fetch_count, and go to VALID; the latency from a PC change to a valid instruction is 1 cycle.
REQ-007 SHALL, in VALID with pc_load=1, set pc<=jump_addr and instr_valid<=0, and go to FETCH.
REQ-008 SHALL, in VALID with pc_enable=1 and pc_load=0, set pc<=pc+1 and instr_valid<=0, and go to FETCH.
REQ-009 SHALL give pc_load priority over pc_enable when both are 1; no increment then occurs.
REQ-010 SHALL, in VALID with neither pc_enable nor pc_load asserted, hold pc, instruction and instr_valid unchanged.
REQ-011 SHALL wrap pc modulo 2^PC_W (15+1 -> 0) with no flag.
REQ-012 SHALL saturate fetch_count at 2^CNT_W-1.
REQ-013 SHALL, when halt=1 in any state, go to HALTED at the next edge, with halt taking priority over pc_load and pc_enable in the same cycle.
REQ-014 SHALL, in HALTED, set instr_valid=0, freeze pc, instruction and fetch_count, and ignore all inputs; only rst exits HALTED.
REQ-015 SHALL set proto_err=1 (sticky) when pc_enable or pc_load is 1 while in FETCH; the request is ignored and FETCH completes normally.
REQ-016 SHALL drive imem_addr combinationally from pc.

Reset
REQ-017 SHALL, on rst asserted at any time (including mid-FETCH or in HALTED), immediately force: state=FETCH, pc=0, instruction=0, instr_valid=0, fetch_count=0, proto_err=0.
REQ-018 SHALL perform its first fetch from address 0 on the first clock edge after rst deasserts.

Configuration
REQ-019 SHALL, when FETCH_PROTO_CHECK_EN is defined, implement proto_err as described in REQ-015.
REQ-020 SHALL, when FETCH_PROTO_CHECK_EN is undefined, tie proto_err to constant 0 with no detection logic; requests in FETCH are still ignored.

Structure
REQ-021 SHALL take PC_W, INSTR_W, the opcode constants (LOAD=0, STORE=1, ADD=2, SUB=3, AND=4, OR=5, JUMP=6, HALT=7) and the FSM state encoding from the shared package cpu_pkg.
REQ-022 SHALL place PC register, wrap and load/increment priority in sub-module program_counter; FSM, instruction register and counter stay in fetch_unit.

Verification
REQ-023 SHALL cover reset then run: imem[0]=0x05, no requests -> after 1 edge instruction=0x05, instr_valid=1, pc=0, fetch_count=1.
REQ-024 SHALL cover a pc_enable pulse in VALID at pc=3 -> next edge pc=4, instr_valid=0; following edge instruction=imem[4], instr_valid=1.
REQ-025 SHALL cover pc_load=1 and pc_enable=1 together with jump_addr=0xA at pc=2 -> pc=0xA, not 3.
REQ-026 SHALL cover pc_enable at pc=15 -> pc=0; the fetch then returns imem[0].
REQ-027 SHALL cover halt=1 with pc_load=1 at pc=6 -> HALTED, pc stays 6, instr_valid=0 permanently; then rst -> pc=0, fetch_count=0.
REQ-028 SHALL cover pc_enable asserted during FETCH -> proto_err=1 and pc unchanged with FETCH_PROTO_CHECK_EN defined; proto_err=0 without it.
